// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Runtime divisors below this select the build-time default rate.
    localparam logic [15:0] DIV_MIN = 16'd2;

    function automatic logic [15:0] eff_div(input logic [15:0] cfg, input logic [15:0] dflt);
        return (cfg < DIV_MIN) ? dflt : cfg;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with level/full/empty; push and pop may occur on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed serialiser with runtime divisor.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [PAYLOAD_BITS-1:0]       s_data,
    input  logic [15:0]                   cfg_div,
    input  logic [1:0]                    cfg_parity,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full
);
    localparam logic [15:0] DEFAULT_DIV = 16'(CLK_HZ / BIT_RATE);
    localparam logic [3:0]  LAST_DATA   = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]  LAST_STOP   = 4'(STOP_BITS - 1);

    tx_state_t               state, state_nxt;
    logic                    pop;
    logic [PAYLOAD_BITS-1:0] head;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic [15:0]             div_q, cyc_cnt;
    logic [3:0]              bit_cnt;
    logic                    period_end;
    logic                    txd_q, txd_nxt;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (s_valid),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign s_ready    = !fifo_full;
    assign tx_busy    = (state != ST_IDLE);
    assign uart_txd   = txd_q;
    assign period_end = (cyc_cnt == div_q - 16'd1);

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_bit_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (pop) begin
            par_en_q  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit_q <= (cfg_parity == PAR_ODD) ? ~^head : ^head;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = ^cfg_parity;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        txd_nxt   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                txd_nxt = 1'b0;
                if (period_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                txd_nxt = shreg[0];
                if (period_end && bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd_nxt = par_bit_q;
                if (period_end) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Chain straight into the next start bit when more data is waiting.
                if (period_end && bit_cnt == LAST_STOP) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            txd_q   <= 1'b1;
            div_q   <= '0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            txd_q <= txd_nxt;
            if (pop) begin
                div_q   <= eff_div(cfg_div, DEFAULT_DIV);
                shreg   <= head;
                cyc_cnt <= '0;
                bit_cnt <= '0;
            end else if (state != ST_IDLE) begin
                if (period_end) begin
                    cyc_cnt <= '0;
                    if (state == ST_DATA) shreg <= shreg >> 1;
                    bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;
                end else begin
                    cyc_cnt <= cyc_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: pushed words are queued, a line monitor decodes frames and compares.
module tb_uart_tx_buffered;

    localparam int CLK_HZ   = 100_000;
    localparam int BIT_RATE = 9600;
    localparam int PB       = 8;
    localparam int SB       = 1;
    localparam int DEPTH    = 16;
    localparam int DEF_DIV  = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef struct {
        logic [PB-1:0] data;
        int            div;
        logic [1:0]    par;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   s_valid;
    logic                   s_ready;
    logic [PB-1:0]          s_data;
    logic [15:0]            cfg_div;
    logic [1:0]             cfg_parity;
    logic                   uart_txd;
    logic                   tx_busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   fifo_empty;
    logic                   fifo_full;

    logic       s_valid2, s_ready2, txd2, busy2, empty2, full2;
    logic [6:0] s_data2;
    logic [2:0] level2;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc = 0;
    int   busy_total = 0;
    int   busy2_total = 0;
    int   n_contig = 0;
    int   last_t0 = -1;
    int   last_end = -1;
    bit   mon_en = 1'b1;

    uart_tx_buffered #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PB),
        .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
        .uart_txd(uart_txd), .tx_busy(tx_busy), .fifo_level(fifo_level),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    uart_tx_buffered #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(7),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_dut2 (
        .clk(clk), .resetn(resetn), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_data(s_data2), .cfg_div(16'd3), .cfg_parity(2'b00),
        .uart_txd(txd2), .tx_busy(busy2), .fifo_level(level2),
        .fifo_empty(empty2), .fifo_full(full2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) busy_total  <= busy_total + int'(tx_busy);
    always @(negedge clk) busy2_total <= busy2_total + int'(busy2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit has_par(input logic [1:0] p);
        return PAR_BUILD && (p == 2'b01 || p == 2'b10);
    endfunction

    function automatic logic exp_par(input exp_t e);
        return (e.par == 2'b01) ? ^e.data : ~^e.data;
    endfunction

    // Line monitor: samples each bit at its midpoint using the expected divisor.
    initial begin : monitor
        exp_t        e;
        logic [15:0] bits;
        int          nb, t0;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (mon_en && resetn && uart_txd === 1'b0) begin
                t0 = cyc;
                aborted = 1'b0;
                bits = '1;
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) e = sb.pop_front();
                else begin e.data = '0; e.div = DEF_DIV; e.par = 2'b00; end
                if (t0 == last_end) n_contig++;
                last_t0  = t0;
                nb       = 1 + PB + (has_par(e.par) ? 1 : 0) + SB;
                last_end = t0 + nb * e.div;
                for (int k = 0; k < nb; k++) begin
                    repeat (k == 0 ? e.div / 2 : e.div) @(negedge clk);
                    if (!mon_en) begin aborted = 1'b1; break; end
                    bits[k] = uart_txd;
                end
                if (!aborted) begin
                    repeat (e.div - e.div / 2 - 1) @(negedge clk);
                    chk("start_bit", 32'(bits[0]), 32'd0);
                    chk("rx_data", 32'(bits[PB:1]), 32'(e.data));
                    if (has_par(e.par)) chk("parity_bit", 32'(bits[PB+1]), 32'(exp_par(e)));
                    chk("stop_bit", 32'(bits[nb-1]), 32'd1);
                end
            end
        end
    end

    task automatic push_word(input logic [PB-1:0] d, input int div, input logic [1:0] par);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (!s_ready && guard < 2000) begin @(negedge clk); guard++; end
        if (guard >= 2000) chk("push_ready_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        e.data = d; e.div = div; e.par = par;
        sb.push_back(e);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        while ((tx_busy || !fifo_empty) && guard < 20000) begin @(negedge clk); guard++; end
        if (guard >= 20000) chk({tag, "_idle_timeout"}, 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin : timeout
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int b0, push_cyc, nc0, accepted, guard;
        logic [9:0]  f2;
        logic [29:0] got2, exp2;

        resetn = 1'b0; s_valid = 1'b0; s_data = '0; cfg_div = 16'd4; cfg_parity = 2'b00;
        s_valid2 = 1'b0; s_data2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, div 4, no parity
        b0 = busy_total;
        push_word(8'hA5, 4, 2'b00);
        push_cyc = cyc;
        wait_idle("a5");
        chk("a5_latency", 32'(last_t0 - push_cyc), 32'd2);
        chk("a5_busy_cycles", 32'(busy_total - b0), 32'd40);

        // Parity modes (bit appears only when compiled in)
        cfg_parity = 2'b01;
        b0 = busy_total;
        push_word(8'h07, 4, 2'b01);
        wait_idle("even");
        chk("even_busy_cycles", 32'(busy_total - b0), PAR_BUILD ? 32'd44 : 32'd40);
        cfg_parity = 2'b10;
        b0 = busy_total;
        push_word(8'h07, 4, 2'b10);
        wait_idle("odd");
        chk("odd_busy_cycles", 32'(busy_total - b0), PAR_BUILD ? 32'd44 : 32'd40);
        cfg_parity = 2'b00;

        // Divisor change mid-frame applies to the next pop only
        cfg_div = 16'd4;
        nc0 = n_contig;
        push_word(8'h5A, 4, 2'b00);
        guard = 0;
        while (!tx_busy && guard < 20) begin @(negedge clk); guard++; end
        chk("chg_busy", 32'(tx_busy), 32'd1);
        cfg_div = 16'd7;
        push_word(8'h3C, 7, 2'b00);
        wait_idle("chg");
        chk("chg_contiguous", 32'(n_contig - nc0), 32'd1);

        // Divisor 0 and 1 fall back to the default rate
        cfg_div = 16'd0;
        b0 = busy_total;
        push_word(8'h69, DEF_DIV, 2'b00);
        wait_idle("div0");
        chk("div0_busy_cycles", 32'(busy_total - b0), 32'(10 * DEF_DIV));
        cfg_div = 16'd1;
        b0 = busy_total;
        push_word(8'h96, DEF_DIV, 2'b00);
        wait_idle("div1");
        chk("div1_busy_cycles", 32'(busy_total - b0), 32'(10 * DEF_DIV));

        // Back-to-back burst until the FIFO fills, then one dropped push
        cfg_div = 16'd2;
        nc0 = n_contig;
        accepted = 0;
        @(negedge clk);
        for (int i = 0; i < 40 && s_ready; i++) begin
            exp_t e;
            s_valid = 1'b1;
            s_data  = 8'(i * 37 + 11);
            e.data = s_data; e.div = 2; e.par = 2'b00;
            sb.push_back(e);
            accepted++;
            @(negedge clk);
        end
        chk("burst_accepted", 32'(accepted), 32'(DEPTH + 1));
        chk("burst_full", 32'(fifo_full), 32'd1);
        chk("burst_ready", 32'(s_ready), 32'd0);
        chk("burst_level", 32'(fifo_level), 32'(DEPTH));
        s_data = 8'hEE;
        @(negedge clk);
        s_valid = 1'b0;
        chk("burst_level_after_drop", 32'(fifo_level), 32'(DEPTH));
        wait_idle("burst");
        chk("burst_contiguous", 32'(n_contig - nc0), 32'(DEPTH));

        // Reset in the middle of a frame with three words queued
        cfg_div = 16'd4;
        for (int i = 0; i < 4; i++) push_word(8'(8'h81 + i), 4, 2'b00);
        repeat (10) @(negedge clk);
        chk("mid_level", 32'(fifo_level), 32'd3);
        mon_en = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_txd", 32'(uart_txd), 32'd1);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        resetn = 1'b1;
        sb.delete();
        b0 = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) b0++;
        end
        chk("post_rst_quiet", 32'(b0), 32'd0);
        mon_en = 1'b1;

        // 7 data bits, 2 stop bits, div 3: 30-clock frame
        f2 = {2'b11, 7'h35, 1'b0};
        for (int i = 0; i < 30; i++) exp2[i] = f2[i / 3];
        @(negedge clk);
        s_valid2 = 1'b1; s_data2 = 7'h35;
        @(negedge clk);
        s_valid2 = 1'b0;
        b0 = busy2_total;
        guard = 0;
        while (txd2 !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
        chk("d2_fall", 32'(txd2), 32'd0);
        for (int i = 0; i < 30; i++) begin
            got2[i] = txd2;
            @(negedge clk);
        end
        chk("d2_frame", 32'(got2), 32'(exp2));
        chk("d2_idle_line", 32'(txd2), 32'd1);
        repeat (5) @(negedge clk);
        chk("d2_busy_cycles", 32'(busy2_total - b0), 32'd30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
